stepdown_core_state_ctrl: RTL and testbench
===========================================

# stepdown_core_state_ctrl

Digital sequencer for the stepdown converter core state. Generates a fixed-frequency PWM, soft-starts the duty from zero to the commanded value, and inserts dead time between high-side and low-side gate enables. Handles overcurrent and undervoltage shutdown. Its `hs_on`/`ls_on` outputs drive the core-state inverter/gate-driver bricks; the power pins pass through for the schematic generator.

## Interface
- `W`, 8: width of the period, duty and counter values.
- `DT_CYCLES`, 3: dead-time length in clk cycles; must be ≥1.
- `FAULT_HOLD`, 255: number of cycles the block stays in FAULT before it may retry.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `CELV`, `CELG`, `SUB` input 1 each: supply, ground and substrate pins; no functional effect in RTL.
- `en` input 1: converter enable.
- `uvlo` input 1: undervoltage lockout, synchronous level.
- `ocp` input 1: overcurrent, synchronous level.
- `period` input W: PWM period in cycles; values below 2 are treated as 2.
- `duty_tgt` input W: target high-side on-count per period.
- `hs_on` output 1: high-side gate enable, registered.
- `ls_on` output 1: low-side gate enable, registered.
- `state` output 2: current state (OFF=0, SOFTSTART=1, RUN=2, FAULT=3).
- `pgood` output 1: high only when `state` is RUN.

## Operation
- Reset value of all outputs and internal registers is 0; `state` resets to OFF.
- Period counter `cnt`:
  - counts 0..P-1 and wraps, where P = max(period, 2);
  - free-runs in SOFTSTART and RUN;
  - held at 0 in OFF and FAULT.
- Active duty `d`:
  - clamped to P-1, so the low side always gets at least one count per period;
  - raw PWM signal `raw` = (cnt < d).
- State transitions:
  - **OFF → SOFTSTART** when `en` is high and `uvlo` is low; `d` and `cnt` start at 0.
  - **SOFTSTART**: at each period wrap (cnt = P-1), `d` increments by 1. When `d` ≥ `duty_tgt` at a wrap, `d` is loaded with `duty_tgt` and the state moves to RUN. If `duty_tgt` = 0, the move to RUN happens at the first wrap.
  - **RUN**: `d` is reloaded from `duty_tgt` only at a wrap; mid-period changes to `duty_tgt` are ignored. Increases and decreases both take effect immediately at the wrap, with no ramp.
  - **Priority from SOFTSTART or RUN**: `uvlo` → OFF; otherwise `ocp` → FAULT; otherwise `en` low → OFF. Leaving SOFTSTART or RUN clears `d`.
  - **FAULT**: a hold counter counts FAULT_HOLD cycles, ignoring `ocp`. After that, the state goes to SOFTSTART if `en` is high, `uvlo` is low and `ocp` is low; otherwise to OFF. `uvlo` in FAULT forces OFF at once.
- Dead time:
  - every transition of `raw` reloads the dead-time counter with DT_CYCLES;
  - `hs_on` = raw and counter = 0;
  - `ls_on` = not raw and counter = 0;
  - a `raw` pulse shorter than DT_CYCLES never reaches the outputs;
  - `hs_on` and `ls_on` are never high together.
- `ls_on` is forced 0 in OFF and FAULT.
- Entry into SOFTSTART reloads the dead-time counter, so the first `ls_on` is delayed by DT_CYCLES.

## Timing
- `en` sampled high at edge N: `state` = SOFTSTART after edge N.
- `ocp` or `uvlo` sampled high at edge N: `hs_on` = `ls_on` = 0 and the new state both take effect at edge N (same edge).
- `raw` changes at edge N: the opposite output drops at edge N; the new output rises at edge N+DT_CYCLES.
- `rst` asserted mid-period: all outputs go to 0 immediately, without waiting for a clock edge.
- After `rst` is released, the first possible transition out of OFF is at the first clock edge.

## Structure
- Package `stepdown_pkg` holds:
  - the state enum and its encodings (OFF, SOFTSTART, RUN, FAULT);
  - the default values of `W`, `DT_CYCLES` and `FAULT_HOLD`.
- Sub-module `stepdown_deadtime`:
  - inputs `clk`, `rst`, `raw`, `arm`;
  - outputs `hs_on`, `ls_on`;
  - contains the dead-time counter and the output registers;
  - `arm` low forces both outputs to 0 and reloads the counter.
- The top level contains the FSM, the period and duty counters and the fault hold counter.

## Test plan
- period=10, duty_tgt=4, DT=3, `en` rises: 4 wraps of SOFTSTART (d=1,2,3,4), then RUN and `pgood`=1.
- RUN, d=4, period=10: `hs_on` high exactly 1 cycle per period, `ls_on` high 3 cycles, never both high.
- duty_tgt=2, DT=3: `hs_on` stays 0; `ls_on` still pulses.
- `ocp` pulse in RUN: both outputs 0 at the same edge, `state`=3 for 255 cycles, then SOFTSTART with d=0.
- `uvlo` and `ocp` high together in RUN: `state`=OFF. `rst` mid-FAULT: `state`=OFF and all outputs 0.
- duty_tgt changed from 4 to 8 mid-period in RUN: `hs_on` width unchanged until the next wrap, then 5 cycles (8 − DT).

Source files
------------

// File: rtl/stepdown_pkg.sv
// -----------------------------------------------------------------------------
// stepdown_pkg
// Shared definitions for the stepdown converter core-state sequencer:
//   - state_t     : sequencer state encoding (also driven out on `state`)
//   - DEF_*       : default values for the W, DT_CYCLES and FAULT_HOLD params
// -----------------------------------------------------------------------------
package stepdown_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_SOFTSTART = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  localparam int unsigned DEF_W          = 8;
  localparam int unsigned DEF_DT_CYCLES  = 3;
  localparam int unsigned DEF_FAULT_HOLD = 255;

endpackage

// File: rtl/stepdown_deadtime.sv
// -----------------------------------------------------------------------------
// stepdown_deadtime
// Dead-time inserter between the high-side and low-side gate enables.
//   clk, rst : clock, asynchronous active-high reset
//   raw      : PWM level for the cycle that starts at the next clock edge
//   arm      : converter active in that cycle; low forces both gates off
//   hs_on    : registered high-side enable
//   ls_on    : registered low-side enable
// A gate turns on only after `raw` has held its level for DT_CYCLES edges,
// so both outputs can never be high together.
// -----------------------------------------------------------------------------
module stepdown_deadtime
  import stepdown_pkg::*;
#(
  parameter int unsigned DT_CYCLES = DEF_DT_CYCLES  // must be >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic arm,
  output logic hs_on,
  output logic ls_on
);

  localparam int unsigned DT_W = $clog2(DT_CYCLES + 1);

  logic [DT_W-1:0] r_dt;
  logic [DT_W-1:0] w_dt_nxt;
  logic            r_raw;
  logic            r_arm;
  logic            r_hs;
  logic            r_ls;
  logic            w_reload;

  // Re-arming counts as an edge of `raw`, so the first gate pulse after
  // leaving OFF/FAULT also waits a full dead time.
  assign w_reload = !arm || !r_arm || (raw != r_raw);

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    w_dt_nxt = '0;
    if (w_reload) begin
      w_dt_nxt = DT_W'(DT_CYCLES);
    end else if (r_dt != '0) begin
      w_dt_nxt = r_dt - DT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dt  <= '0;
      r_raw <= 1'b0;
      r_arm <= 1'b0;
      r_hs  <= 1'b0;
      r_ls  <= 1'b0;
    end else begin
      r_dt  <= w_dt_nxt;
      r_raw <= raw;
      r_arm <= arm;
      r_hs  <= arm &&  raw && (w_dt_nxt == '0);
      r_ls  <= arm && !raw && (w_dt_nxt == '0);
    end
  end

  assign hs_on = r_hs;
  assign ls_on = r_ls;

endmodule

// File: rtl/stepdown_core_state_ctrl.sv
// -----------------------------------------------------------------------------
// stepdown_core_state_ctrl
// Core-state sequencer for the stepdown converter: fixed-frequency PWM,
// soft-start duty ramp, dead time, overcurrent/undervoltage shutdown.
//   clk, rst          : clock, asynchronous active-high reset
//   CELV, CELG, SUB   : supply/ground/substrate pass-through, no function
//   en                : converter enable
//   uvlo, ocp         : undervoltage / overcurrent, synchronous levels
//   period            : PWM period in cycles (values < 2 act as 2)
//   duty_tgt          : target high-side on-count per period
//   hs_on, ls_on      : registered gate enables
//   state             : OFF=0, SOFTSTART=1, RUN=2, FAULT=3
//   pgood             : high while in RUN
// -----------------------------------------------------------------------------
module stepdown_core_state_ctrl
  import stepdown_pkg::*;
#(
  parameter int unsigned W          = DEF_W,
  parameter int unsigned DT_CYCLES  = DEF_DT_CYCLES,   // must be >= 1
  parameter int unsigned FAULT_HOLD = DEF_FAULT_HOLD   // must be >= 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         CELV,
  input  logic         CELG,
  input  logic         SUB,
  input  logic         en,
  input  logic         uvlo,
  input  logic         ocp,
  input  logic [W-1:0] period,
  input  logic [W-1:0] duty_tgt,
  output logic         hs_on,
  output logic         ls_on,
  output logic [1:0]   state,
  output logic         pgood
);

  localparam int unsigned       HOLD_W    = (FAULT_HOLD > 1) ? $clog2(FAULT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAULT_HOLD - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W-1:0]      r_cnt;
  logic [W-1:0]      w_cnt_nxt;
  logic [W-1:0]      r_d;
  logic [W-1:0]      w_d_nxt;
  logic [W-1:0]      w_d_inc;
  logic [W-1:0]      w_p;
  logic [W-1:0]      w_p_m1;
  logic [W-1:0]      w_d_eff;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_wrap;
  logic              w_arm_nxt;
  logic              w_raw_nxt;
  logic              w_unused_pins;

  // Power pins exist only for the schematic generator.
  assign w_unused_pins = ^{CELV, CELG, SUB};

  assign w_p     = (period < W'(2)) ? W'(2) : period;
  assign w_p_m1  = w_p - W'(1);
  // >= rather than == keeps the counter bounded if the period shrinks mid-run.
  assign w_wrap  = (r_cnt >= w_p_m1);
  assign w_d_inc = r_d + W'(1);

  // Next-state logic. Leaving SOFTSTART/RUN falls through to the zero
  // defaults, which clears both the period counter and the duty.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_d_nxt     = '0;
    w_hold_nxt  = '0;
    unique case (r_state)
      ST_OFF: begin
        if (en && !uvlo) w_state_nxt = ST_SOFTSTART;
      end
      ST_SOFTSTART, ST_RUN: begin
        if (uvlo) begin
          w_state_nxt = ST_OFF;
        end else if (ocp) begin
          w_state_nxt = ST_FAULT;
        end else if (!en) begin
          w_state_nxt = ST_OFF;
        end else begin
          w_cnt_nxt = w_wrap ? '0 : r_cnt + W'(1);
          w_d_nxt   = r_d;
          if (w_wrap) begin
            if (r_state == ST_RUN) begin
              w_d_nxt = duty_tgt;
            end else if (w_d_inc >= duty_tgt) begin
              w_d_nxt     = duty_tgt;
              w_state_nxt = ST_RUN;
            end else begin
              w_d_nxt = w_d_inc;
            end
          end
        end
      end
      ST_FAULT: begin
        if (uvlo) begin
          w_state_nxt = ST_OFF;
        end else if (r_hold == HOLD_LAST) begin
          w_state_nxt = (en && !ocp) ? ST_SOFTSTART : ST_OFF;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // The dead-time block registers its outputs, so it is fed the PWM level and
  // arm for the coming cycle; a shutdown then drops both gates on the very
  // edge that changes state.
  always_comb begin
    w_arm_nxt = (w_state_nxt == ST_SOFTSTART) || (w_state_nxt == ST_RUN);
    // Clamp keeps at least one low-side count per period.
    w_d_eff   = (w_d_nxt > w_p_m1) ? w_p_m1 : w_d_nxt;
    w_raw_nxt = (w_cnt_nxt < w_d_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_d     <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d     <= w_d_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  stepdown_deadtime #(
    .DT_CYCLES(DT_CYCLES)
  ) u_deadtime (
    .clk  (clk),
    .rst  (rst),
    .raw  (w_raw_nxt),
    .arm  (w_arm_nxt),
    .hs_on(hs_on),
    .ls_on(ls_on)
  );

  assign state = r_state;
  assign pgood = (r_state == ST_RUN);

endmodule

// File: tb/tb_stepdown_core_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepdown_core_state_ctrl
// Self-checking bench: a directed vector table, hand-written corner-case
// sequences, and randomized stimulus compared every cycle against a
// behavioural model. The model derives the gate enables from a window of the
// last DT+1 PWM levels rather than from a dead-time counter.
// -----------------------------------------------------------------------------
module tb_stepdown_core_state_ctrl;

  localparam int W    = 8;
  localparam int DT   = 3;
  localparam int HOLD = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         celv;
  logic         celg;
  logic         sub;
  logic         en;
  logic         uvlo;
  logic         ocp;
  logic [W-1:0] period;
  logic [W-1:0] duty_tgt;
  logic         hs_on;
  logic         ls_on;
  logic [1:0]   state;
  logic         pgood;

  int n_vec = 0;
  int n_bad = 0;

  stepdown_core_state_ctrl #(
    .W(W), .DT_CYCLES(DT), .FAULT_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .CELV(celv), .CELG(celg), .SUB(sub),
    .en(en), .uvlo(uvlo), .ocp(ocp), .period(period), .duty_tgt(duty_tgt),
    .hs_on(hs_on), .ls_on(ls_on), .state(state), .pgood(pgood)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] dut_vec();
    return {state, hs_on, ls_on, pgood};
  endfunction

  // ---------------- behavioural model ----------------
  // States: 0 OFF, 1 SOFTSTART, 2 RUN, 3 FAULT.
  int m_state, m_cnt, m_d, m_fc;
  int hist[$];  // newest first; 1/0 = PWM level while active, 2 = inactive

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_d = 0; m_fc = 0;
    hist.delete();
    for (int i = 0; i <= DT; i++) hist.push_back(2);
  endfunction

  function automatic void model_step();
    int  p;
    int  deff;
    bit  act;
    if (rst) begin
      model_reset();
      return;
    end
    p = (int'(period) < 2) ? 2 : int'(period);
    case (m_state)
      0: if (en && !uvlo) begin m_state = 1; m_cnt = 0; m_d = 0; end
      1, 2: begin
        if (uvlo || ocp || !en) begin
          m_state = (!uvlo && ocp) ? 3 : 0;
          m_cnt = 0; m_d = 0; m_fc = 1;
        end else if (m_cnt == p - 1) begin
          m_cnt = 0;
          if (m_state == 2) m_d = int'(duty_tgt);
          else if (m_d + 1 >= int'(duty_tgt)) begin m_d = int'(duty_tgt); m_state = 2; end
          else m_d = m_d + 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      default: begin
        if (uvlo) m_state = 0;
        else if (m_fc == HOLD) m_state = (en && !ocp) ? 1 : 0;
        else m_fc = m_fc + 1;
      end
    endcase
    act  = (m_state == 1) || (m_state == 2);
    deff = (m_d < p - 1) ? m_d : p - 1;
    void'(hist.pop_back());
    hist.push_front(act ? ((m_cnt < deff) ? 1 : 0) : 2);
  endfunction

  function automatic logic [4:0] model_vec();
    bit hs = 1'b1;
    bit ls = 1'b1;
    foreach (hist[i]) begin
      if (hist[i] != 1) hs = 1'b0;
      if (hist[i] != 0) ls = 1'b0;
    end
    return {2'(m_state), hs, ls, (m_state == 2)};
  endfunction

  task automatic tick(input bit vs_model);
    @(posedge clk);
    model_step();
    #1;
    if (vs_model) check("model", int'(dut_vec()), int'(model_vec()));
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n = 0;
    while (int'(state) != st && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(state), st);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst, en, uvlo, ocp;
    logic [7:0] period, duty;
    logic [1:0] st;
    logic       hs, ls, pg;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int r, input int e, input int u, input int o,
                              input int p, input int d,
                              input int st, input int h, input int l, input int g);
    vec_t v;
    v.rst = (r != 0); v.en = (e != 0); v.uvlo = (u != 0); v.ocp = (o != 0);
    v.period = 8'(p); v.duty = 8'(d);
    v.st = 2'(st); v.hs = (h != 0); v.ls = (l != 0); v.pg = (g != 0);
    tbl.push_back(v);
  endfunction

  initial begin
    int n, w1, w2, hs_n, ls_n, both_n;

    rst = 1'b1; celv = 1'b1; celg = 1'b0; sub = 1'b0;
    en = 1'b0; uvlo = 1'b0; ocp = 1'b0; period = 8'd4; duty_tgt = 8'd2;
    model_reset();

    // period 4, duty 2: entry, first ls after DT, 2 soft-start wraps, faults.
    //   rst en uv ocp  P  D   st hs ls pg
    add(1, 0, 0, 0,   4, 2,  0, 0, 0, 0);
    add(0, 0, 0, 0,   4, 2,  0, 0, 0, 0);
    add(0, 1, 0, 0,   4, 2,  1, 0, 0, 0);  // enter SOFTSTART, cnt=0
    add(0, 1, 0, 0,   4, 2,  1, 0, 0, 0);
    add(0, 1, 0, 0,   4, 2,  1, 0, 0, 0);
    add(0, 1, 0, 0,   4, 2,  1, 0, 1, 0);  // ls after DT edges
    add(0, 1, 0, 0,   4, 2,  1, 0, 0, 0);  // wrap, d=1, raw rises
    add(0, 1, 0, 0,   4, 2,  1, 0, 0, 0);
    add(0, 1, 0, 0,   4, 2,  1, 0, 0, 0);
    add(0, 1, 0, 0,   4, 2,  1, 0, 0, 0);
    add(0, 1, 0, 0,   4, 2,  2, 0, 0, 1);  // wrap, d=2 -> RUN
    add(0, 1, 0, 1,   4, 2,  3, 0, 0, 0);  // ocp -> FAULT
    add(0, 1, 1, 0,   4, 2,  0, 0, 0, 0);  // uvlo in FAULT -> OFF
    add(0, 1, 1, 0,   4, 2,  0, 0, 0, 0);  // uvlo blocks start
    add(0, 1, 0, 0,   4, 2,  1, 0, 0, 0);
    add(0, 1, 0, 0,   4, 2,  0, 0, 0, 0);  // synchronous view of reset
    add(0, 0, 0, 0,   4, 2,  0, 0, 0, 0);
    tbl[15].rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; en = tbl[i].en; uvlo = tbl[i].uvlo; ocp = tbl[i].ocp;
      period = tbl[i].period; duty_tgt = tbl[i].duty;
      tick(0);
      check($sformatf("tbl[%0d]", i), int'(dut_vec()),
            int'({tbl[i].st, tbl[i].hs, tbl[i].ls, tbl[i].pg}));
    end

    // Soft start period 10, duty 4: four wraps (40 cycles) then RUN.
    period = 8'd10; duty_tgt = 8'd4;
    tick(1);
    en = 1'b1;
    tick(1);
    check("ss_entry", int'(state), 1);
    n = 0;
    while (state != 2'd2 && n < 100) begin tick(1); n++; end
    check("ss_len", n, 40);
    check("pgood_run", int'(pgood), 1);

    // RUN d=4: hs 1 cycle, ls 3 cycles per period, never both.
    hs_n = 0; ls_n = 0; both_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      hs_n += int'(hs_on); ls_n += int'(ls_on); both_n += int'(hs_on & ls_on);
    end
    check("d4_hs_cnt", hs_n, 1);
    check("d4_ls_cnt", ls_n, 3);
    check("d4_overlap", both_n, 0);

    // duty 2 < DT: hs suppressed, ls 5 cycles per period.
    duty_tgt = 8'd2;
    for (int i = 0; i < 20; i++) tick(1);
    hs_n = 0; ls_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      hs_n += int'(hs_on); ls_n += int'(ls_on);
    end
    check("d2_hs_cnt", hs_n, 0);
    check("d2_ls_cnt", ls_n, 5);

    // Mid-period change 4 -> 8: current pulse unchanged, next pulse 8-DT.
    duty_tgt = 8'd4;
    for (int i = 0; i < 20; i++) tick(1);
    n = 0;
    while (!hs_on && n < 30) begin tick(1); n++; end
    check("hs_seen", int'(hs_on), 1);
    duty_tgt = 8'd8;
    w1 = 0;
    while (hs_on && w1 < 20) begin w1++; tick(1); end
    n = 0;
    while (!hs_on && n < 30) begin tick(1); n++; end
    w2 = 0;
    while (hs_on && w2 < 20) begin w2++; tick(1); end
    check("hs_width_old", w1, 1);
    check("hs_width_new", w2, 8 - DT);

    // ocp pulse in RUN: same-edge shutdown, 255 cycles of FAULT, restart.
    wait_state(2, 30, "run_before_ocp");
    ocp = 1'b1;
    tick(1);
    check("ocp_edge", int'(dut_vec()), {2'd3, 1'b0, 1'b0, 1'b0});
    ocp = 1'b0;
    n = 0;
    while (state == 2'd3 && n < 400) begin n++; tick(1); end
    check("fault_len", n, HOLD);
    check("fault_exit", int'(state), 1);
    wait_state(2, 200, "run_after_fault");

    // uvlo and ocp together in RUN: uvlo wins.
    uvlo = 1'b1; ocp = 1'b1;
    tick(1);
    check("uvlo_ocp", int'(dut_vec()), 0);
    uvlo = 1'b0; ocp = 1'b0;
    duty_tgt = 8'd4;

    // Asynchronous reset in the middle of FAULT.
    tick(1);
    ocp = 1'b1;
    tick(1);
    ocp = 1'b0;
    for (int i = 0; i < 5; i++) tick(1);
    check("in_fault", int'(state), 3);
    #2 rst = 1'b1;
    #1 check("async_rst_fault", int'(dut_vec()), 0);
    model_reset();
    tick(1);
    rst = 1'b0;

    // Asynchronous reset while a gate is on in RUN.
    wait_state(2, 100, "run_before_rst");
    n = 0;
    while (!ls_on && n < 20) begin tick(1); n++; end
    check("ls_seen", int'(ls_on), 1);
    #2 rst = 1'b1;
    #1 check("async_rst_run", int'(dut_vec()), 0);
    model_reset();
    tick(1);
    rst = 1'b0;

    // Randomized segments against the model.
    for (int s = 0; s < 12; s++) begin
      en = 1'b0; uvlo = 1'b0; ocp = 1'b0;
      tick(1);
      tick(1);
      period   = 8'($urandom_range(0, 12));
      duty_tgt = 8'($urandom_range(0, 14));
      en = 1'b1;
      for (int i = 0; i < 350; i++) begin
        uvlo = ($urandom_range(0, 299) == 0);
        ocp  = ($urandom_range(0, 249) == 0);
        if ($urandom_range(0, 399) == 0) en = !en;
        if ($urandom_range(0, 39) == 0) duty_tgt = 8'($urandom_range(0, 14));
        tick(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
